sw_debouncer: RTL and testbench

- Conditions the raw board slide-switch inputs before they are captured by the switch peripheral register.
- Synchronizes each asynchronous switch line into the 10 MHz processor clock domain.
- Filters mechanical bounce with an independent per-bit stability counter.
- Outputs a clean 16-bit vector for the register's data input, plus a one-cycle change strobe the bus/interrupt logic can use.

---
 rtl/sw_debouncer.sv | 62 ++++++
 tb/tb_sw_debouncer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - two-flop synchronizer and per-bit stability filter for slide switches
// Each bit is accepted only after DEBOUNCE_CYCLES consecutive synchronized samples disagree with data_o.
module sw_debouncer #(
   parameter int N_SW            = 16,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [N_SW-1:0] sw_i,
   output logic [N_SW-1:0] data_o,
   output logic            changed_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N_SW-1:0]            sync1_q;
   logic [N_SW-1:0]            sync2_q;
   logic [N_SW-1:0]            data_q;
   logic [N_SW-1:0]            data_d;
   logic [N_SW-1:0][CNT_W-1:0] cnt_q;
   logic [N_SW-1:0][CNT_W-1:0] cnt_d;
   logic                       changed_q;
   logic                       changed_d;

   // A matching sample clears the count, so bounce progress never carries over.
   always_comb begin
      data_d = data_q;
      cnt_d  = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (sync2_q[i] != data_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               data_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      changed_d = |(data_d ^ data_q);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= sw_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         changed_q <= changed_d;
      end
   end

   assign data_o    = data_q;
   assign changed_o = changed_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// tb/tb_sw_debouncer.sv - self-checking bench for sw_debouncer with a sample-window reference model
// The model accepts a bit when the DC samples taken 2..DC+1 edges ago all disagree with the accepted level.
module tb_sw_debouncer;

   localparam int NSW = 16;
   localparam int DC  = 4;

   logic           clk_i;
   logic           rst_n_i;
   logic [NSW-1:0] sw_i;
   logic [NSW-1:0] data_o;
   logic           changed_o;

   int checks;
   int errors;

   sw_debouncer #(
      .N_SW(NSW),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk_i(clk_i),
      .rst_n_i(rst_n_i),
      .sw_i(sw_i),
      .data_o(data_o),
      .changed_o(changed_o)
   );

   initial clk_i = 1'b0;
   always #50 clk_i = ~clk_i;

   // hist[0] is the sample taken at the previous edge, hist[k] k edges before that.
   logic [NSW-1:0] hist [0:DC];
   logic [NSW-1:0] m_data;
   logic           m_changed;

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k <= DC; k++) hist[k] <= '0;
         m_data    <= '0;
         m_changed <= 1'b0;
      end else begin
         logic [NSW-1:0] nd;
         logic           all_diff;
         nd = m_data;
         for (int b = 0; b < NSW; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DC; k++)
               if (hist[k][b] == m_data[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_data[b];
         end
         m_changed <= (nd != m_data);
         m_data    <= nd;
         hist[0]   <= sw_i;
         for (int k = 1; k <= DC; k++) hist[k] <= hist[k-1];
      end
   end

   task automatic settle(input logic [NSW-1:0] v);
      @(negedge clk_i);
      sw_i = v;
      repeat (12) @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      sw_i    = '1;
      repeat (6) begin
         @(negedge clk_i);
         checks += 2;
         if (data_o !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp %h", data_o, 16'h0000); end
         if (changed_o !== 1'b0) begin errors++; $display("FAIL reset_changed got %b exp %b", changed_o, 1'b0); end
      end
      sw_i    = '0;
      rst_n_i = 1'b1;
      repeat (8) begin
         @(negedge clk_i);
         checks += 2;
         if (data_o !== 16'h0000) begin errors++; $display("FAIL post_reset_data got %h exp %h", data_o, 16'h0000); end
         if (changed_o !== 1'b0) begin errors++; $display("FAIL post_reset_changed got %b exp %b", changed_o, 1'b0); end
      end
   endtask

   task automatic test_clean_step();
      logic [NSW-1:0] exp_d;
      settle(16'h0000);
      sw_i = 16'h00A5;
      for (int k = 0; k <= 8; k++) begin
         @(posedge clk_i); #1;
         exp_d = (k >= 5) ? 16'h00A5 : 16'h0000;
         checks += 3;
         if (data_o !== exp_d) begin errors++; $display("FAIL step_data k=%0d got %h exp %h", k, data_o, exp_d); end
         if (changed_o !== (k == 5)) begin errors++; $display("FAIL step_changed k=%0d got %b exp %b", k, changed_o, (k == 5)); end
         if (data_o !== m_data) begin errors++; $display("FAIL step_model k=%0d got %h exp %h", k, data_o, m_data); end
      end
   endtask

   task automatic test_bounce();
      int pulses;
      pulses = 0;
      settle(16'h0000);
      for (int v = 0; v < 4; v++) begin
         sw_i[3] = (v % 2 == 0);
         repeat (2) begin
            @(negedge clk_i);
            if (changed_o === 1'b1) pulses++;
            checks++;
            if (data_o[3] !== 1'b0) begin errors++; $display("FAIL bounce_hold got %b exp %b", data_o[3], 1'b0); end
         end
      end
      sw_i[3] = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(posedge clk_i); #1;
         if (changed_o === 1'b1) pulses++;
         checks++;
         if (data_o[3] !== (k >= 5)) begin errors++; $display("FAIL bounce_accept k=%0d got %b exp %b", k, data_o[3], (k >= 5)); end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL bounce_pulses got %0d exp %0d", pulses, 1); end
   endtask

   task automatic test_short_glitch();
      settle(16'h0000);
      sw_i[15] = 1'b1;
      repeat (3) @(negedge clk_i);
      sw_i[15] = 1'b0;
      repeat (10) begin
         @(negedge clk_i);
         checks += 2;
         if (data_o !== 16'h0000) begin errors++; $display("FAIL glitch_data got %h exp %h", data_o, 16'h0000); end
         if (changed_o !== 1'b0) begin errors++; $display("FAIL glitch_changed got %b exp %b", changed_o, 1'b0); end
      end
   endtask

   task automatic test_independent_bits();
      logic [NSW-1:0] exp_d;
      settle(16'h0000);
      sw_i = 16'h0001;
      for (int k = 0; k <= 9; k++) begin
         @(posedge clk_i); #1;
         exp_d = (k >= 7) ? 16'h0003 : (k >= 5) ? 16'h0001 : 16'h0000;
         checks += 2;
         if (data_o !== exp_d) begin errors++; $display("FAIL indep_data k=%0d got %h exp %h", k, data_o, exp_d); end
         if (changed_o !== (k == 5 || k == 7)) begin errors++; $display("FAIL indep_changed k=%0d got %b exp %b", k, changed_o, (k == 5 || k == 7)); end
         if (k == 1) begin @(negedge clk_i); sw_i = 16'h0003; end
      end
      @(negedge clk_i);
      sw_i = 16'h0033;
      for (int k = 0; k <= 7; k++) begin
         @(posedge clk_i); #1;
         exp_d = (k >= 5) ? 16'h0033 : 16'h0003;
         checks += 2;
         if (data_o !== exp_d) begin errors++; $display("FAIL same_edge_data k=%0d got %h exp %h", k, data_o, exp_d); end
         if (changed_o !== (k == 5)) begin errors++; $display("FAIL same_edge_changed k=%0d got %b exp %b", k, changed_o, (k == 5)); end
      end
   endtask

   task automatic test_long_hold();
      int pulses;
      pulses = 0;
      settle(16'h0000);
      sw_i = 16'hFFFF;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk_i); #1;
         if (changed_o === 1'b1) pulses++;
      end
      checks += 2;
      if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d exp %0d", pulses, 1); end
      if (data_o !== 16'hFFFF) begin errors++; $display("FAIL hold_data got %h exp %h", data_o, 16'hFFFF); end
      @(negedge clk_i);
      sw_i = 16'h0000;
      for (int k = 0; k <= 7; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (data_o !== ((k >= 5) ? 16'h0000 : 16'hFFFF)) begin
            errors++; $display("FAIL release_data k=%0d got %h exp %h", k, data_o, ((k >= 5) ? 16'h0000 : 16'hFFFF));
         end
      end
   endtask

   task automatic test_async_reset();
      settle(16'hFFFF);
      @(negedge clk_i);
      sw_i = 16'h0000;
      repeat (4) @(posedge clk_i);
      #20;
      rst_n_i = 1'b0;
      #1;
      checks += 2;
      if (data_o !== 16'h0000) begin errors++; $display("FAIL async_rst_data got %h exp %h", data_o, 16'h0000); end
      if (changed_o !== 1'b0) begin errors++; $display("FAIL async_rst_changed got %b exp %b", changed_o, 1'b0); end
      sw_i = 16'hFFFF;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (data_o !== ((k >= 5) ? 16'hFFFF : 16'h0000)) begin
            errors++; $display("FAIL rst_restart k=%0d got %h exp %h", k, data_o, ((k >= 5) ? 16'hFFFF : 16'h0000));
         end
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         checks += 2;
         if (data_o !== m_data) begin errors++; $display("FAIL rand_data c=%0d got %h exp %h", c, data_o, m_data); end
         if (changed_o !== m_changed) begin errors++; $display("FAIL rand_changed c=%0d got %b exp %b", c, changed_o, m_changed); end
         if (hold == 0) begin
            sw_i = sw_i ^ NSW'($urandom & $urandom);
            hold = $urandom_range(1, 7);
         end else begin
            hold--;
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n_i = 1'b0;
      sw_i    = '0;
      test_reset();
      test_clean_step();
      test_bounce();
      test_short_glitch();
      test_independent_bits();
      test_long_hold();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
